// File: rtl/bfp_align_buffer.sv
// Buffers one block of bf16 result words, then drains it as block-floating-point
// signed fixed point aligned to the block's maximum exponent.
module bfp_align_buffer #(
    parameter int BLOCK_LEN = 64,
    parameter int ADDR_W    = 6,
    parameter int OUT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        in_data,
    input  logic               in_vld,
    output logic               in_ready,
    input  logic [7:0]         max_exp,
    input  logic               max_exp_vld,
    output logic               max_exp_ready,
    output logic [4*OUT_W-1:0] out_data,
    output logic               out_vld,
    input  logic               out_ready,
    output logic [7:0]         out_exp,
    output logic               out_last,
    output logic               err_exp,
    output logic               err_special
);
    // state    | meaning
    // FILL     | accepting words into the buffer at wptr
    // WAIT_EXP | block captured, waiting for the block max exponent
    // DRAIN    | reading buffer, aligning lanes, emitting words
    typedef enum logic [1:0] {FILL, WAIT_EXP, DRAIN} state_t;

    localparam int                MAG_W     = OUT_W - 1;
    localparam logic [OUT_W-1:0]  SAT       = {1'b0, {MAG_W{1'b1}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_LEN - 1);

    state_t             state, state_nxt;
    logic [63:0]        mem [BLOCK_LEN];
    logic [ADDR_W-1:0]  wptr, rptr;
    logic               rd_done, rd_vld, rd_last;
    logic [63:0]        rd_data;
    logic               wr_en, exp_hs, rd_issue, pop, last_pop;
    logic [1:0]         occ;
    logic [4*OUT_W-1:0] conv_data, skid_data;
    logic               conv_err_exp, conv_err_special;
    logic               skid_vld, skid_last;
    logic [OUT_W+1:0]   lane_res;

    // Returns {special, exp_err, lane}.
    function automatic logic [OUT_W+1:0] conv_lane(input logic [15:0] w, input logic [7:0] mx);
        logic [MAG_W-1:0] mag;
        logic [7:0]       d;
        logic [OUT_W-1:0] v;
        logic             ee, es;
        ee  = 1'b0;
        es  = 1'b0;
        v   = '0;
        d   = '0;
        mag = MAG_W'({1'b1, w[6:0]}) << (OUT_W - 9);
        if (w[14:7] == 8'hFF) begin
            es = 1'b1;
            v  = w[15] ? -SAT : SAT;
        end else if (w[14:7] != 8'h00) begin
            if (w[14:7] > mx) ee = 1'b1;
            else              d  = mx - w[14:7];
            if (int'(d) >= MAG_W) mag = '0;
            else                  mag = mag >> d;
            v = w[15] ? -{1'b0, mag} : {1'b0, mag};
        end
        return {es, ee, v};
    endfunction

    assign wr_en    = in_vld && (state == FILL);
    assign exp_hs   = max_exp_vld && (state == WAIT_EXP);
    assign pop      = out_vld && out_ready;
    assign last_pop = pop && out_last;
    // Every issued read must have a free landing slot in the output or skid register.
    assign occ      = 2'(out_vld) + 2'(skid_vld) + 2'(rd_vld);
    assign rd_issue = (state == DRAIN) && !rd_done && ((occ - 2'(pop)) < 2'd2);

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        max_exp_ready = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (wr_en && (wptr == LAST_ADDR)) state_nxt = WAIT_EXP;
            end
            WAIT_EXP: begin
                max_exp_ready = 1'b1;
                if (max_exp_vld) state_nxt = DRAIN;
            end
            DRAIN: if (last_pop) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        conv_data        = '0;
        conv_err_exp     = 1'b0;
        conv_err_special = 1'b0;
        lane_res         = '0;
        for (int k = 0; k < 4; k++) begin
            lane_res = conv_lane(rd_data[16*k +: 16], out_exp);
            conv_data[OUT_W*k +: OUT_W] = lane_res[OUT_W-1:0];
            conv_err_exp     = conv_err_exp | lane_res[OUT_W];
            conv_err_special = conv_err_special | lane_res[OUT_W+1];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)    mem[wptr] <= in_data;
        if (rd_issue) rd_data   <= mem[rptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            wptr        <= '0;
            rptr        <= '0;
            rd_done     <= 1'b0;
            rd_vld      <= 1'b0;
            rd_last     <= 1'b0;
            out_exp     <= '0;
            out_data    <= '0;
            out_vld     <= 1'b0;
            out_last    <= 1'b0;
            skid_data   <= '0;
            skid_vld    <= 1'b0;
            skid_last   <= 1'b0;
            err_exp     <= 1'b0;
            err_special <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= rd_issue;
            if (wr_en)  wptr    <= wptr + 1'b1;
            if (exp_hs) out_exp <= max_exp;
            if (rd_issue) begin
                rd_last <= (rptr == LAST_ADDR);
                rptr    <= rptr + 1'b1;
                if (rptr == LAST_ADDR) rd_done <= 1'b1;
            end
            if (last_pop) rd_done <= 1'b0;
            if (!out_vld || pop) begin
                if (skid_vld) begin
                    out_data <= skid_data;
                    out_last <= skid_last;
                    out_vld  <= 1'b1;
                    skid_vld <= rd_vld;
                    if (rd_vld) begin
                        skid_data <= conv_data;
                        skid_last <= rd_last;
                    end
                end else begin
                    out_vld  <= rd_vld;
                    out_last <= rd_vld && rd_last;
                    if (rd_vld) out_data <= conv_data;
                end
            end else if (rd_vld) begin
                skid_data <= conv_data;
                skid_last <= rd_last;
                skid_vld  <= 1'b1;
            end
            if (rd_vld) begin
                err_exp     <= err_exp | conv_err_exp;
                err_special <= err_special | conv_err_special;
            end
        end
    end
endmodule

// File: tb/tb_bfp_align_buffer.sv
// Self-checking bench for bfp_align_buffer: random blocks drained under several
// out_ready patterns and compared against an arithmetic bf16-to-fixed model.
module tb_bfp_align_buffer;
    localparam int BL = 64;
    localparam int OW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [63:0]       in_data = '0;
    logic              in_vld = 1'b0;
    logic              in_ready;
    logic [7:0]        max_exp = '0;
    logic              max_exp_vld = 1'b0;
    logic              max_exp_ready;
    logic [4*OW-1:0]   out_data;
    logic              out_vld;
    logic              out_ready = 1'b0;
    logic [7:0]        out_exp;
    logic              out_last;
    logic              err_exp;
    logic              err_special;

    bfp_align_buffer #(.BLOCK_LEN(BL), .ADDR_W(6), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_vld(in_vld), .in_ready(in_ready),
        .max_exp(max_exp), .max_exp_vld(max_exp_vld), .max_exp_ready(max_exp_ready),
        .out_data(out_data), .out_vld(out_vld), .out_ready(out_ready),
        .out_exp(out_exp), .out_last(out_last),
        .err_exp(err_exp), .err_special(err_special)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int              vectors = 0;
    int              miscompares = 0;
    logic [63:0]     blk [BL];
    logic [4*OW-1:0] exp_words [BL];
    logic [4*OW-1:0] got_data [$];
    bit              got_last [$];
    bit              m_err_exp = 1'b0;
    bit              m_err_spec = 1'b0;
    int              hs_cyc, first_vld_cyc, stall_viol;
    bit              coll_timeout;

    // Value of a bf16 lane as fixed point with 2^(OW-9) scaling at the block exponent.
    function automatic logic [OW-1:0] ref_lane(input logic [15:0] w, input int mx,
                                               output bit ee, output bit es);
        int e, m, d, mag;
        e  = int'(w[14:7]);
        m  = int'(w[6:0]);
        ee = 1'b0;
        es = 1'b0;
        if (e == 0) return '0;
        if (e == 255) begin
            es = 1'b1;
            return w[15] ? OW'(-(2**(OW-1) - 1)) : OW'(2**(OW-1) - 1);
        end
        if (e > mx) begin ee = 1'b1; d = 0; end
        else d = mx - e;
        mag = (d >= 31) ? 0 : (((128 + m) * 2**(OW-9)) >> d);
        return w[15] ? OW'(-mag) : OW'(mag);
    endfunction

    task automatic build_exp(input int mx);
        bit ee, es;
        for (int i = 0; i < BL; i++)
            for (int k = 0; k < 4; k++) begin
                exp_words[i][OW*k +: OW] = ref_lane(blk[i][16*k +: 16], mx, ee, es);
                m_err_exp  = m_err_exp | ee;
                m_err_spec = m_err_spec | es;
            end
    endtask

    function automatic logic [15:0] rand_lane(input int mx);
        int e;
        e = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(mx, mx - 18));
        return {1'($urandom_range(1)), 8'(e), 7'($urandom_range(127))};
    endfunction

    task automatic gen_block(input int mx);
        for (int i = 0; i < BL; i++)
            blk[i] = {rand_lane(mx), rand_lane(mx), rand_lane(mx), rand_lane(mx)};
    endtask

    task automatic fill_block(input bit gaps, input bit pulse, output int bad);
        bad = 0;
        for (int i = 0; i < BL; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                in_vld  = 1'b0;
                in_data = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            in_vld  = 1'b1;
            in_data = blk[i];
            max_exp = 8'd200;
            max_exp_vld = pulse && (i < 10) && (i % 2 == 0);
            if (in_ready !== 1'b1 || max_exp_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        max_exp_vld = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] mx, input int delay, input bit garbage,
                            output bit tmo, output int bad);
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            if (garbage) begin in_vld = 1'b1; in_data = {$urandom, $urandom}; end
            if (max_exp_ready !== 1'b1 || in_ready !== 1'b0 || out_vld !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        max_exp = mx;
        max_exp_vld = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (max_exp_ready === 1'b1) begin tmo = 1'b0; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        hs_cyc = cyc;
        max_exp_vld = 1'b0;
        max_exp = 8'($urandom);
    endtask

    // mode 0: always ready, 1: 1,0,0,1,0,1 repeating, 2: random.
    task automatic collect(input int mode, input int max_words, input bit garbage);
        logic [4*OW-1:0] prev_data;
        bit prev_stall;
        int n;
        got_data.delete();
        got_last.delete();
        stall_viol = 0; first_vld_cyc = -1; coll_timeout = 1'b1;
        prev_stall = 1'b0; prev_data = '0; n = 0;
        for (int c = 0; c < 4000; c++) begin
            if (garbage) begin in_vld = 1'b1; in_data = {$urandom, $urandom}; end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 5);
                default: out_ready = 1'($urandom_range(1));
            endcase
            if (prev_stall && (out_vld !== 1'b1 || out_data !== prev_data)) stall_viol++;
            if (out_vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
            prev_stall = (out_vld === 1'b1) && !out_ready;
            prev_data  = out_data;
            if (out_vld === 1'b1 && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                n++;
            end
            @(posedge clk); #1;
            if (n == max_words) begin coll_timeout = 1'b0; break; end
        end
        in_vld = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, max_exp_ready, out_vld, out_last, out_data, out_exp, err_exp, err_special}
            !== {1'b1, 1'b0, 1'b0, 1'b0, {4*OW{1'b0}}, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: in_rdy=%b exp_rdy=%b vld=%b last=%b data=%h exp=%h errs=%b%b, want 1 0 0 0 0 0 00",
                     in_ready, max_exp_ready, out_vld, out_last, out_data, out_exp, err_exp, err_special);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_ramp;
        int bad; bit tmo;
        for (int i = 0; i < BL; i++) blk[i] = 64'h3F80_3F80_3F80_3F80;
        fill_block(1'b0, 1'b0, bad);
        send_exp(8'd127, 0, 1'b0, tmo, bad);
        collect(0, BL, 1'b0);
        build_exp(127);
        vectors++;
        if (got_data.size() != BL || coll_timeout) begin
            miscompares++;
            $display("FAIL ramp_count: got %0d words (timeout=%b), want %0d", got_data.size(), coll_timeout, BL);
        end
        for (int i = 0; i < BL && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== 64'h4000_4000_4000_4000 || got_last[i] !== (i == BL - 1)) begin
                miscompares++;
                $display("FAIL ramp_word %0d: got %h last=%b, want 4000400040004000 last=%b",
                         i, got_data[i], got_last[i], i == BL - 1);
            end
        end
        vectors++;
        if (out_exp !== 8'd127 || in_ready !== 1'b1 || out_vld !== 1'b0 || tmo) begin
            miscompares++;
            $display("FAIL ramp_end: exp=%0d in_rdy=%b vld=%b tmo=%b, want 127 1 0 0", out_exp, in_ready, out_vld, tmo);
        end
    endtask

    task automatic run_block(input string name, input int mx, input int mode);
        int bad; bit tmo;
        fill_block(1'b1, 1'b0, bad);
        send_exp(8'(mx), int'($urandom_range(3)), 1'b0, tmo, bad);
        collect(mode, BL, 1'b0);
        build_exp(mx);
        vectors++;
        if (got_data.size() != BL || coll_timeout || tmo || stall_viol != 0) begin
            miscompares++;
            $display("FAIL %s_flow: words=%0d timeout=%b exp_tmo=%b stall_viol=%0d, want %0d 0 0 0",
                     name, got_data.size(), coll_timeout, tmo, stall_viol, BL);
        end
        for (int i = 0; i < BL && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_words[i] || got_last[i] !== (i == BL - 1)) begin
                miscompares++;
                $display("FAIL %s_word %0d: got %h last=%b, want %h last=%b",
                         name, i, got_data[i], got_last[i], exp_words[i], i == BL - 1);
            end
        end
        vectors++;
        if (out_exp !== 8'(mx) || err_exp !== m_err_exp || err_special !== m_err_spec) begin
            miscompares++;
            $display("FAIL %s_status: exp=%0d err_exp=%b err_spec=%b, want %0d %b %b",
                     name, out_exp, err_exp, err_special, mx, m_err_exp, m_err_spec);
        end
    endtask

    task automatic test_align;
        gen_block(127);
        blk[0][15:0]  = 16'h3F00;
        blk[0][31:16] = {1'b0, 8'd100, 7'h55};
        run_block("align127", 127, 2);
        vectors++;
        if (got_data[0][31:0] !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL align_half_and_far: got %h want 00002000", got_data[0][31:0]);
        end
        gen_block(128);
        blk[0][15:0] = 16'hBFC0;
        run_block("align128", 128, 0);
        vectors++;
        if (got_data[0][15:0] !== 16'hD000) begin
            miscompares++;
            $display("FAIL align_neg: got %h want d000", got_data[0][15:0]);
        end
    endtask

    task automatic test_flags;
        gen_block(127);
        blk[5][15:0]  = 16'h7F80;
        blk[9][47:32] = 16'h4100;
        run_block("flags", 127, 0);
        vectors++;
        if (got_data[5][15:0] !== 16'h7FFF || got_data[9][47:32] !== 16'h4000
            || err_exp !== 1'b1 || err_special !== 1'b1) begin
            miscompares++;
            $display("FAIL flags_direct: sat=%h over=%h errs=%b%b, want 7fff 4000 11",
                     got_data[5][15:0], got_data[9][47:32], err_exp, err_special);
        end
    endtask

    task automatic test_backpressure;
        gen_block(128);
        run_block("backpressure", 128, 1);
    endtask

    task automatic test_handshake;
        int fbad, wbad; bit tmo;
        gen_block(127);
        fill_block(1'b0, 1'b1, fbad);
        send_exp(8'd127, 10, 1'b1, tmo, wbad);
        collect(2, BL, 1'b1);
        build_exp(127);
        vectors++;
        if (fbad != 0 || wbad != 0 || tmo) begin
            miscompares++;
            $display("FAIL hs_ready: fill_bad=%0d wait_bad=%0d tmo=%b, want 0 0 0", fbad, wbad, tmo);
        end
        vectors++;
        if (first_vld_cyc - hs_cyc != 2) begin
            miscompares++;
            $display("FAIL hs_latency: got %0d cycles want 2", first_vld_cyc - hs_cyc);
        end
        vectors++;
        if (got_data.size() != BL || out_exp !== 8'd127) begin
            miscompares++;
            $display("FAIL hs_block: words=%0d exp=%0d, want %0d 127", got_data.size(), out_exp, BL);
        end
        for (int i = 0; i < BL && i < got_data.size(); i++) begin
            vectors++;
            if (got_data[i] !== exp_words[i]) begin
                miscompares++;
                $display("FAIL hs_word %0d: got %h want %h", i, got_data[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain;
        int bad; bit tmo;
        gen_block(127);
        fill_block(1'b0, 1'b0, bad);
        send_exp(8'd127, 0, 1'b0, tmo, bad);
        collect(0, 20, 1'b0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, max_exp_ready, out_vld, out_last, out_data, out_exp, err_exp, err_special}
            !== {1'b1, 1'b0, 1'b0, 1'b0, {4*OW{1'b0}}, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: in_rdy=%b exp_rdy=%b vld=%b last=%b data=%h exp=%h errs=%b%b, want 1 0 0 0 0 0 00",
                     in_ready, max_exp_ready, out_vld, out_last, out_data, out_exp, err_exp, err_special);
        end
        m_err_exp = 1'b0;
        m_err_spec = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        gen_block(128);
        run_block("post_reset", 128, 2);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_align();
        test_flags();
        test_backpressure();
        test_handshake();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bfp_align_buffer.md
Name: bfp_align_buffer

Overview:
- Sits directly downstream of the bf16 multiplier-tree top.
- Captures one block of BLOCK_LEN 64-bit result words (4 bf16 lanes each) into an internal buffer, then waits for the block's maximum exponent from the upstream max-exponent tracker.
- Drains the block as block-floating-point data: each lane's significand is right-shifted by (max_exp - lane_exp) and converted to signed fixed point, ready for the integer accumulator stage.

Parameters:
- BLOCK_LEN, 64, words per block (buffer depth); power of two, ≥2.
- ADDR_W, 6, log2(BLOCK_LEN).
- OUT_W, 16, signed width of each aligned output lane; ≥9.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  64  four bf16 lanes; lane k = bits [16k+15:16k].
- in_vld  input  1  in_data valid (driven by multiplier-tree output_vld).
- in_ready  output  1  buffer accepting words.
- max_exp  input  8  block max exponent from the tracker.
- max_exp_vld  input  1  max_exp valid.
- max_exp_ready  output  1  drives the tracker's max_exponent_ready.
- out_data  output  4*OUT_W  aligned signed lanes; lane k = bits [OUT_W*(k+1)-1:OUT_W*k].
- out_vld  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_exp  output  8  shared block exponent; held for the whole drain.
- out_last  output  1  final word of the block.
- err_exp  output  1  sticky: a lane exponent exceeded max_exp.
- err_special  output  1  sticky: a lane exponent was 255 (inf/NaN).

Behaviour:
- Reset (asynchronous, rst=0):
  - Outputs: in_ready=1, max_exp_ready=0, out_vld=0, out_last=0, out_data=0, out_exp=0, err_exp=0, err_special=0.
  - State FILL; write and read pointers = 0.
  - Reset asserted mid-block discards buffered data; the first accepted word after reset release is word 0.
- FSM states: FILL, WAIT_EXP, DRAIN.
- FILL:
  - A word is written at wptr when in_vld & in_ready; wptr increments.
  - On the write with wptr=BLOCK_LEN-1: wptr wraps to 0, in_ready drops the next cycle, state goes to WAIT_EXP.
  - in_vld while in_ready=0 is ignored. Words are not back-pressured, so upstream must respect in_ready.
- WAIT_EXP:
  - max_exp_ready=1.
  - On max_exp_vld & max_exp_ready: latch max_exp into out_exp, drop max_exp_ready next cycle, go to DRAIN.
  - max_exp_vld seen in FILL or DRAIN is ignored (max_exp_ready=0 there).
- DRAIN:
  - Buffer read has 1-cycle latency. A one-entry output register plus a one-entry skid register sustain 1 word/cycle under continuous out_ready.
  - First out_vld appears 2 cycles after the exponent handshake.
  - out_data and out_vld are held stable while out_vld & !out_ready.
  - out_last=1 exactly with the word from address BLOCK_LEN-1.
  - On the handshake of that word: out_vld=0 next cycle (unless a new block is already valid, which cannot happen here), state returns to FILL, in_ready=1 next cycle.
  - out_exp keeps its value until the next exponent latch.
- Lane conversion (combinational on read data, registered into out_data):
  - Fields: s=bit15, e=bits[14:7], m=bits[6:0].
  - e==0 → lane = 0 (zero/denormal flushed).
  - e==255 → lane saturates to ±(2^(OUT_W-1)-1) by s; sets err_special.
  - Otherwise sig = {1,m} (8 bits) and mag = {sig, (OUT_W-9) zeros} (OUT_W-1 bits).
    - d = out_exp - e (8-bit unsigned).
    - e > out_exp → d forced to 0; sets err_exp.
    - d ≥ OUT_W-1 → mag = 0; else mag = mag >> d, truncating with no rounding.
    - lane = s ? -mag : mag, OUT_W-bit two's complement.
- Sticky flags: err_exp and err_special are cleared only by reset.
- Simultaneous events: none cross states, because input and output phases are exclusive. out_ready toggling every cycle must not drop or duplicate words.

Test Plan:
- Ramp block, BLOCK_LEN=64: fill all lanes with 0x3F80 (1.0, e=127); then max_exp=127 → 64 words, each lane = 0x4000, out_last only on word 63, out_exp=127, in_ready=1 after the last handshake.
- Alignment: a lane of 0x3F00 (0.5, e=126) with max_exp=127 → 0x2000. A lane of 0xBFC0 (-1.5) with max_exp=128 → -0x3000 = 0xD000. A lane with e=100, max_exp=127 (d=27) → 0.
- Flags: a lane of 0x7F80 → 0x7FFF with err_special=1. A lane with e=130, max_exp=127 → d=0, err_exp=1, both sticky through the next block.
- Backpressure: out_ready pattern 1,0,0,1,0,1 repeating → exactly 64 words in address order, data stable across stalls, no duplicates.
- Handshake ordering: max_exp_vld pulsed during FILL is ignored (max_exp_ready=0). During WAIT_EXP, max_exp_vld arrives 10 cycles late → first out_vld exactly 2 cycles after the handshake. in_vld during WAIT_EXP and DRAIN is not written.
- Reset mid-DRAIN after 20 words: all outputs go to reset values asynchronously. After release, a full new block drains correctly starting from word 0.
